// File: rtl/usb_pkg.sv
// Shared definitions for the USB FIFO bridge transmit path.
//   USB_BYTE_W         : width of one stream byte
//   DEF_FIFO_BUS_WIDTH : default packed word width in bytes
//   pack_state_e       : packer FSM states
//   be_from_count(n)   : mask with the n low bits set
package usb_pkg;

  localparam int unsigned USB_BYTE_W         = 8;
  localparam int unsigned DEF_FIFO_BUS_WIDTH = 4;
  localparam int unsigned USB_MAX_BUS_W      = 64;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_e;

  // Byte-enable mask for a word holding n bytes from lane 0 upward.
  function automatic logic [USB_MAX_BUS_W-1:0] be_from_count(input int unsigned n);
    logic [USB_MAX_BUS_W-1:0] be;
    be = '0;
    for (int unsigned i = 0; i < USB_MAX_BUS_W; i++) begin
      be[i] = (i < n);
    end
    return be;
  endfunction

endpackage

// File: rtl/usb_word_reg.sv
// Output register for packed words with a valid/ready handshake.
//   clk_i, rst_i      : clock, asynchronous active-high reset
//   in_valid_i        : a closed word is offered for loading
//   in_data_i/be_i/last_i : offered word payload
//   out_free_c_o      : register empty or being drained this cycle (combinational)
//   m_data_o/be_o/last_o/valid_o, m_ready_i : downstream handshake
module usb_word_reg
  import usb_pkg::*;
#(
  parameter int unsigned BYTES = DEF_FIFO_BUS_WIDTH
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          in_valid_i,
  input  logic [BYTES*USB_BYTE_W-1:0]   in_data_i,
  input  logic [BYTES-1:0]              in_be_i,
  input  logic                          in_last_i,
  output logic                          out_free_c_o,
  output logic [BYTES*USB_BYTE_W-1:0]   m_data_o,
  output logic [BYTES-1:0]              m_be_o,
  output logic                          m_last_o,
  output logic                          m_valid_o,
  input  logic                          m_ready_i
);

  localparam int unsigned DW = BYTES * USB_BYTE_W;

  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [BYTES-1:0] be_q, be_d;
  logic          last_q, last_d;

  assign out_free_c_o = !valid_q || m_ready_i;

  // Payload only changes on a load, so it stays stable while stalled.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    be_d    = be_q;
    last_d  = last_q;
    if (out_free_c_o) begin
      valid_d = in_valid_i;
      if (in_valid_i) begin
        data_d = in_data_i;
        be_d   = in_be_i;
        last_d = in_last_i;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      be_q    <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      be_q    <= be_d;
      last_q  <= last_d;
    end
  end

  assign m_valid_o = valid_q;
  assign m_data_o  = data_q;
  assign m_be_o    = be_q;
  assign m_last_o  = last_q;

endmodule

// File: rtl/usb_tx_packer.sv
// Packs a byte stream little-endian into FIFO_BUS_WIDTH-byte words with byte
// enables. Words close on a full word, s_last, flush_req or an idle timeout.
//   tx_clk, rst_glbl            : clock, asynchronous active-high reset
//   s_data/s_valid/s_last/s_ready : input byte stream
//   flush_req                   : close the current partial word
//   m_data/m_be/m_last/m_valid/m_ready : packed word output
//   stat_words                  : wrapping count of words handed over
module usb_tx_packer
  import usb_pkg::*;
#(
  parameter int unsigned FIFO_BUS_WIDTH = DEF_FIFO_BUS_WIDTH,
  parameter int unsigned FLUSH_TIMEOUT  = 256
) (
  input  logic                               tx_clk,
  input  logic                               rst_glbl,
  input  logic [USB_BYTE_W-1:0]              s_data,
  input  logic                               s_valid,
  input  logic                               s_last,
  output logic                               s_ready,
  input  logic                               flush_req,
  output logic [FIFO_BUS_WIDTH*USB_BYTE_W-1:0] m_data,
  output logic [FIFO_BUS_WIDTH-1:0]          m_be,
  output logic                               m_last,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic [31:0]                        stat_words
);

  localparam int unsigned W  = FIFO_BUS_WIDTH;
  localparam int unsigned DW = W * USB_BYTE_W;
  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1);

  pack_state_e state_q, state_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_q, last_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          ready_q, ready_d;
  logic [31:0]   stat_q, stat_d;

  logic          accept;
  logic          close;
  logic          timeout;
  logic [DW-1:0] fill_acc;
  logic [CW-1:0] fill_cnt;
  logic          word_valid;
  logic [DW-1:0] word_data;
  logic [W-1:0]  word_be;
  logic          word_last;
  logic          out_free;

  // Packing FSM, idle timer and word hand-off to the output register.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    last_d     = last_q;
    timer_d    = timer_q;
    accept     = s_valid && ready_q;
    close      = 1'b0;
    timeout    = 1'b0;
    fill_acc   = acc_q;
    fill_cnt   = cnt_q;
    word_valid = 1'b0;
    word_data  = acc_q;
    word_be    = W'(be_from_count(32'(cnt_q)));
    word_last  = last_q;

    case (state_q)
      FILL: begin
        for (int unsigned k = 0; k < W; k++) begin
          if (accept && cnt_q == CW'(k)) fill_acc[k*USB_BYTE_W +: USB_BYTE_W] = s_data;
        end
        if (accept) fill_cnt = cnt_q + CW'(1);
        timeout = !accept && (cnt_q != '0) && (timer_q == TW'(FLUSH_TIMEOUT - 1));
        // A flush with a byte arriving the same cycle still closes, including that byte.
        close = (accept && (cnt_q == CW'(W - 1) || s_last)) ||
                (flush_req && fill_cnt != '0) || timeout;
        if (close) begin
          word_data = fill_acc;
          word_be   = W'(be_from_count(32'(fill_cnt)));
          word_last = accept && s_last;
          timer_d   = '0;
          if (out_free) begin
            word_valid = 1'b1;
            acc_d      = '0;
            cnt_d      = '0;
            last_d     = 1'b0;
          end else begin
            // Park the closed word in the accumulator until the output drains.
            acc_d   = fill_acc;
            cnt_d   = fill_cnt;
            last_d  = accept && s_last;
            state_d = HOLD;
          end
        end else begin
          acc_d = fill_acc;
          cnt_d = fill_cnt;
          if (accept) timer_d = '0;
          else if (cnt_q != '0) timer_d = timer_q + TW'(1);
        end
      end
      HOLD: begin
        word_valid = 1'b1;
        if (out_free) begin
          acc_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    ready_d = (state_d == FILL);
    stat_d  = stat_q + 32'(m_valid && m_ready);
  end

  always_ff @(posedge tx_clk or posedge rst_glbl) begin
    if (rst_glbl) begin
      state_q <= FILL;
      acc_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      timer_q <= '0;
      ready_q <= 1'b0;
      stat_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      ready_q <= ready_d;
      stat_q  <= stat_d;
    end
  end

  usb_word_reg #(
    .BYTES(W)
  ) u_word_reg (
    .clk_i        (tx_clk),
    .rst_i        (rst_glbl),
    .in_valid_i   (word_valid),
    .in_data_i    (word_data),
    .in_be_i      (word_be),
    .in_last_i    (word_last),
    .out_free_c_o (out_free),
    .m_data_o     (m_data),
    .m_be_o       (m_be),
    .m_last_o     (m_last),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready)
  );

  assign s_ready    = ready_q;
  assign stat_words = stat_q;

endmodule
